if_ent_arbiter: RTL

//  - Shares one IfEnt-style 8-bit compute datapath (ports A, B -> XOUT) among NREQ requesters.
//  - Round-robin grant, valid/ready request and response channels, registered result tagged with requester ID.
//  - Datapath latency is a parameter, so the same controller also drives a pipelined datapath variant.

---
 rtl/if_ent_arbiter.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/if_ent_arbiter.sv
// ---------------------------------------------------------------------------
// if_ent_arbiter
//
// Shares a single 8-bit IfEnt-style compute datapath (dp_a, dp_b -> dp_xout)
// between NREQ requesters. Requests are granted round-robin. One transaction
// is in flight at a time: IDLE -> ISSUE -> WAIT (DP_LAT cycles) -> RESP.
// The captured result is tagged with the owning requester's index.
//
// Parameters
//   NREQ    number of requesters, 2..8
//   DP_LAT  cycles from dp_a/dp_b driven to dp_xout valid, 1..15
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  [NREQ]    per-requester operand valid
//   req_a      [8*NREQ]  operand A, requester i in bits [8*i+7:8*i]
//   req_b      [8*NREQ]  operand B, same packing
//   req_ready  [NREQ]    one-hot accept pulse to the granted requester
//   dp_a/dp_b  [8]       registered operands to the datapath
//   dp_xout    [8]       datapath result
//   rsp_valid            result valid, held until rsp_ready
//   rsp_data   [8]       captured dp_xout
//   rsp_id     [3]       requester index owning rsp_data
//   rsp_ready            response consumer ready
//   stat_cnt   [16]      completed-transaction count
//
// Build option
//   IF_ARB_STATS_EN  when defined, stat_cnt counts response handshakes and
//                    saturates at 16'hFFFF; otherwise stat_cnt is tied to 0.
// ---------------------------------------------------------------------------
module if_ent_arbiter #(
  parameter int NREQ   = 4,
  parameter int DP_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        dp_a,
  output logic [7:0]        dp_b,
  input  logic [7:0]        dp_xout,
  output logic              rsp_valid,
  output logic [7:0]        rsp_data,
  output logic [2:0]        rsp_id,
  input  logic              rsp_ready,
  output logic [15:0]       stat_cnt
);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("if_ent_arbiter: NREQ=%0d outside 2..8", NREQ);
  end
  if (DP_LAT < 1 || DP_LAT > 15) begin : g_bad_lat
    $error("if_ent_arbiter: DP_LAT=%0d outside 1..15", DP_LAT);
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] NREQ_W   = 4'(NREQ);
  localparam logic [3:0] LAT_LOAD = 4'(DP_LAT - 1);

  state_t      state_reg, state_next;
  logic [2:0]  rr_reg;
  logic [2:0]  grant_reg;
  logic [3:0]  cnt_reg;
  logic [7:0]  dp_a_reg, dp_b_reg;
  logic        rsp_valid_reg;
  logic [7:0]  rsp_data_reg;
  logic [2:0]  rsp_id_reg;

  logic        issue, capture, rsp_hs;
  logic [2:0]  grant_sel;
  logic [3:0]  scan_idx;
  logic        found;
  logic [3:0]  grant_inc;
  logic [2:0]  rr_wrap;

  // Operand slices padded to 8 entries so a 3-bit grant can index them
  // directly regardless of NREQ.
  logic [7:0]  a_arr [8];
  logic [7:0]  b_arr [8];
  logic [15:0] valid_pad;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_slice
      if (gi < NREQ) begin : g_used
        assign a_arr[gi] = req_a[8*gi +: 8];
        assign b_arr[gi] = req_b[8*gi +: 8];
      end else begin : g_pad
        assign a_arr[gi] = 8'h00;
        assign b_arr[gi] = 8'h00;
      end
    end
  endgenerate

  assign valid_pad = 16'(req_valid);

  // Round-robin pick: first valid requester at or after rr_reg, wrapping.
  always_comb begin
    grant_sel = rr_reg;
    scan_idx  = 4'd0;
    found     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, rr_reg} + 4'(k);
      if (scan_idx >= NREQ_W) scan_idx = scan_idx - NREQ_W;
      if (!found && valid_pad[scan_idx]) begin
        found     = 1'b1;
        grant_sel = scan_idx[2:0];
      end
    end
  end

  assign grant_inc = {1'b0, grant_reg} + 4'd1;
  assign rr_wrap   = (grant_inc >= NREQ_W) ? 3'd0 : grant_inc[2:0];

  // Next-state and strobes
  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    capture    = 1'b0;
    rsp_hs     = 1'b0;
    req_ready  = '0;
    case (state_reg)
      IDLE: begin
        if (|req_valid) state_next = ISSUE;
      end
      ISSUE: begin
        issue = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
          req_ready[k] = (grant_reg == 3'(k));
        end
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_hs     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      rr_reg        <= 3'd0;
      grant_reg     <= 3'd0;
      cnt_reg       <= 4'd0;
      dp_a_reg      <= 8'h00;
      dp_b_reg      <= 8'h00;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= 8'h00;
      rsp_id_reg    <= 3'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && (|req_valid)) grant_reg <= grant_sel;
      if (issue) begin
        dp_a_reg <= a_arr[grant_reg];
        dp_b_reg <= b_arr[grant_reg];
        cnt_reg  <= LAT_LOAD;
      end else if (state_reg == WAIT && cnt_reg != 4'd0) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
      if (capture) begin
        rsp_data_reg  <= dp_xout;
        rsp_id_reg    <= grant_reg;
        rsp_valid_reg <= 1'b1;
      end
      if (rsp_hs) begin
        rsp_valid_reg <= 1'b0;
        rr_reg        <= rr_wrap;
      end
    end
  end

  assign dp_a      = dp_a_reg;
  assign dp_b      = dp_b_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_id    = rsp_id_reg;

`ifdef IF_ARB_STATS_EN
  logic [15:0] stat_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_reg <= 16'h0000;
    end else if (rsp_hs && stat_reg != 16'hFFFF) begin
      stat_reg <= stat_reg + 16'd1;
    end
  end
  assign stat_cnt = stat_reg;
`else
  assign stat_cnt = 16'h0000;
`endif

endmodule
